// File: rtl/mult_div_unit_if.sv
// Purpose : request/result bundle between the control unit and mult_div_unit.
// Latency : n/a (wiring only).
// Backpressure: master must hold off start/hi_wr/lo_wr while busy is high.
// Ports   : master drives start/op/a/b/hi_wr/lo_wr/wr_data,
//           slave drives busy/done/div_zero/hi/lo.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_wr;
    logic             lo_wr;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_wr, lo_wr, wr_data,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_wr, lo_wr, wr_data,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Purpose : iterative MULT/MULTU/DIV/DIVU with HI/LO registers and direct HI/LO writes.
// Latency : WIDTH+1 edges from accept to done; divide-by-zero flags done one cycle after accept.
// Backpressure: busy high while computing; start/hi_wr/lo_wr ignored until busy drops.
// Ports   : clk, reset (async active-low), bus (slave side of mult_div_unit_if).
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            reset,
    mult_div_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d;   // quotient / product sign
    logic             neg_rem_q, neg_rem_d;   // remainder follows dividend sign
    logic [WIDTH-1:0] mcand_q, mcand_d;       // multiplicand or divisor magnitude
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;     // product upper half / partial remainder
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;     // multiplier bits / dividend-quotient bits
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;

    logic             sgn_op, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_tmp;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [2*WIDTH-1:0] prod, prod_fix;

    always_comb begin
        sgn_op = ~bus.op[0];
        a_neg  = sgn_op & bus.a[WIDTH-1];
        b_neg  = sgn_op & bus.b[WIDTH-1];
        a_mag  = a_neg ? -bus.a : bus.a;
        b_mag  = b_neg ? -bus.b : bus.b;

        // Multiply step: carry out of the add lands in the accumulator MSB after the shift.
        mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);

        // Divide step: the true difference is always < divisor, so WIDTH bits suffice.
        div_tmp  = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_ge   = (div_tmp >= {1'b0, mcand_q});
        div_diff = div_tmp[WIDTH-1:0] - mcand_q;

        prod     = {acc_hi_q, acc_lo_q};
        prod_fix = neg_res_q ? -prod : prod;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        mcand_d   = mcand_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dz_d      = dz_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    dz_d = 1'b0;
                    if (bus.op[1] && (bus.b == '0)) begin
                        done_d = 1'b1;
                        dz_d   = 1'b1;
                    end else begin
                        is_div_d  = bus.op[1];
                        neg_res_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        acc_hi_d  = '0;
                        acc_lo_d  = bus.op[1] ? a_mag : b_mag;
                        mcand_d   = bus.op[1] ? b_mag : a_mag;
                        cnt_d     = CW'(WIDTH);
                        state_d   = S_CALC;
                    end
                end else begin
                    if (bus.hi_wr) hi_d = bus.wr_data;
                    if (bus.lo_wr) lo_d = bus.wr_data;
                end
            end
            S_CALC: begin
                if (is_div_q) begin
                    acc_hi_d = div_ge ? div_diff : div_tmp[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
                end else begin
                    acc_hi_d = mul_sum[WIDTH:1];
                    acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (is_div_q) begin
                    lo_d = neg_res_q ? -acc_lo_q : acc_lo_q;
                    hi_d = neg_rem_q ? -acc_hi_q : acc_hi_q;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            mcand_q   <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            mcand_q   <= mcand_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Purpose : directed checks of mult_div_unit at WIDTH=32 and WIDTH=8.
// Latency : n/a (bench).
// Backpressure: n/a (bench).
module tb_mult_div_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    mult_div_unit_if #(.WIDTH(32)) bus32();
    mult_div_unit_if #(.WIDTH(8))  bus8();

    mult_div_unit #(.WIDTH(32)) dut32 (.clk(clk), .reset(rst_n), .bus(bus32));
    mult_div_unit #(.WIDTH(8))  dut8  (.clk(clk), .reset(rst_n), .bus(bus8));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit w8, input logic st, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic hw, input logic lw, input logic [31:0] wd);
        if (w8) begin
            bus8.start = st; bus8.op = op; bus8.a = a[7:0]; bus8.b = b[7:0];
            bus8.hi_wr = hw; bus8.lo_wr = lw; bus8.wr_data = wd[7:0];
        end else begin
            bus32.start = st; bus32.op = op; bus32.a = a; bus32.b = b;
            bus32.hi_wr = hw; bus32.lo_wr = lw; bus32.wr_data = wd;
        end
    endtask

    function automatic logic get_busy(input bit w8);
        return w8 ? bus8.busy : bus32.busy;
    endfunction

    function automatic logic get_done(input bit w8);
        return w8 ? bus8.done : bus32.done;
    endfunction

    function automatic logic [63:0] get_hilo(input bit w8);
        return w8 ? {24'd0, bus8.hi, 24'd0, bus8.lo} : {bus32.hi, bus32.lo};
    endfunction

    // Called one step after the accept edge; counts edges until done.
    task automatic wait_done(input bit w8, output int lat, output int bcnt);
        bit seen = 1'b0;
        bcnt = get_busy(w8) ? 1 : 0;
        lat = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            step();
            lat++;
            if (get_done(w8)) seen = 1'b1;
            else if (get_busy(w8)) bcnt++;
        end
        if (!seen) check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_op(input bit w8, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int lat, output int bcnt);
        set_in(w8, 1'b1, op, a, b, 1'b0, 1'b0, 32'd0);
        step();
        set_in(w8, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        wait_done(w8, lat, bcnt);
    endtask

    initial begin
        int lat, bcnt;
        set_in(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        set_in(1'b1, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        step();
        step();
        check("rst_busy", {63'd0, bus32.busy}, 64'd0);
        check("rst_done", {63'd0, bus32.done}, 64'd0);
        check("rst_dz",   {63'd0, bus32.div_zero}, 64'd0);
        check("rst_hilo", get_hilo(1'b0), 64'd0);
        rst_n = 1'b1;
        step();

        // MULTU max*max
        run_op(1'b0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
        check("multu_max", get_hilo(1'b0), 64'hFFFF_FFFE_0000_0001);
        check("multu_lat", 64'(lat), 64'd33);
        check("multu_busy", 64'(bcnt), 64'd33);
        check("multu_busy_after", {63'd0, bus32.busy}, 64'd0);
        step();
        check("done_falls", {63'd0, bus32.done}, 64'd0);

        run_op(1'b0, 2'b00, 32'hFFFF_FFFD, 32'd7, lat, bcnt);
        check("mult_neg", get_hilo(1'b0), 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(1'b0, 2'b00, 32'h8000_0000, 32'h8000_0000, lat, bcnt);
        check("mult_minmin", get_hilo(1'b0), 64'h4000_0000_0000_0000);

        run_op(1'b0, 2'b10, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
        check("div_neg", get_hilo(1'b0), 64'hFFFF_FFFF_FFFF_FFFD);
        check("div_lat", 64'(lat), 64'd33);
        run_op(1'b0, 2'b11, 32'd7, 32'd2, lat, bcnt);
        check("divu_7_2", get_hilo(1'b0), 64'h0000_0001_0000_0003);
        run_op(1'b0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
        check("div_ovf", get_hilo(1'b0), 64'h0000_0000_8000_0000);

        // Preload HI/LO, then divide by zero
        set_in(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b0, 32'h1234);
        step();
        set_in(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b1, 32'h5678);
        step();
        set_in(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        check("preload", get_hilo(1'b0), 64'h0000_1234_0000_5678);
        check("wr_no_done", {63'd0, bus32.done}, 64'd0);
        set_in(1'b0, 1'b1, 2'b11, 32'd5, 32'd0, 1'b0, 1'b0, 32'd0);
        step();
        set_in(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        check("dz_flags", {61'd0, bus32.done, bus32.div_zero, bus32.busy}, 64'b110);
        check("dz_hilo", get_hilo(1'b0), 64'h0000_1234_0000_5678);
        step();
        check("dz_hold", {62'd0, bus32.done, bus32.div_zero}, 64'b01);

        // MULTU 6x7 with contention while busy
        set_in(1'b0, 1'b1, 2'b01, 32'd6, 32'd7, 1'b0, 1'b0, 32'd0);
        step();
        check("dz_cleared", {63'd0, bus32.div_zero}, 64'd0);
        set_in(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        step();
        step();
        set_in(1'b0, 1'b1, 2'b11, 32'd100, 32'd3, 1'b1, 1'b1, 32'hDEAD);
        step();
        set_in(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        wait_done(1'b0, lat, bcnt);
        check("busy_ignore", get_hilo(1'b0), 64'd42);
        check("busy_ignore_lat", 64'(lat + 3), 64'd33);

        // Back-to-back start in the done cycle, with lo_wr that must be dropped
        set_in(1'b0, 1'b1, 2'b01, 32'd3, 32'd5, 1'b0, 1'b1, 32'hBEEF);
        step();
        set_in(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        check("b2b_accept", {63'd0, bus32.busy}, 64'd1);
        wait_done(1'b0, lat, bcnt);
        check("b2b_result", get_hilo(1'b0), 64'd15);

        // Simultaneous HI/LO write
        set_in(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b1, 32'h55);
        step();
        set_in(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        check("wr_both", get_hilo(1'b0), 64'h0000_0055_0000_0055);

        // Reset in the middle of a MULTU
        set_in(1'b0, 1'b1, 2'b01, 32'd6, 32'd7, 1'b0, 1'b0, 32'd0);
        step();
        set_in(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 10; i++) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {63'd0, bus32.busy}, 64'd0);
        check("mid_rst_hilo", get_hilo(1'b0), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        step();
        check("post_rst_idle", {62'd0, bus32.busy, bus32.done}, 64'd0);

        // WIDTH=8 instance
        run_op(1'b1, 2'b01, 32'd6, 32'd7, lat, bcnt);
        check("w8_multu", get_hilo(1'b1), 64'd42);
        check("w8_lat", 64'(lat), 64'd9);
        run_op(1'b1, 2'b10, 32'h80, 32'hFF, lat, bcnt);
        check("w8_div_ovf", get_hilo(1'b1), 64'h80);
        run_op(1'b1, 2'b00, 32'hFD, 32'd7, lat, bcnt);
        check("w8_mult_neg", get_hilo(1'b1), 64'h0000_00FF_0000_00EB);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
